// File: rtl/spart_pkg.sv
// Shared mini-SPART definitions.
//   RX_FIFO_DEPTH : default receive buffer depth (entries)
//   BYTE_W        : serial character width
//   byte_t        : one character, used by rx, tx, the bus interface and the FIFO
package spart_pkg;

  localparam int unsigned RX_FIFO_DEPTH = 16;
  localparam int unsigned BYTE_W        = 8;

  typedef logic [BYTE_W-1:0] byte_t;

endpackage : spart_pkg

// File: rtl/rx_fifo_if.sv
// Receive-FIFO handshake bundle between the UART receiver / bus interface
// (master side) and the rx_fifo (slave side).
//   rx_data, rda      : received byte and its data-available strobe/level
//   rd_en, clr_ovr    : pop request and overrun clear from the bus interface
//   rd_data           : show-ahead head byte (zero when empty)
//   empty, full       : occupancy flags
//   count             : stored byte count, 0..DEPTH
//   overrun           : sticky byte-dropped flag
interface rx_fifo_if #(
  parameter int unsigned AW = 4
);
  import spart_pkg::*;

  byte_t         rx_data;
  logic          rda;
  logic          rd_en;
  logic          clr_ovr;
  byte_t         rd_data;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          overrun;

  modport master (
    output rx_data, rda, rd_en, clr_ovr,
    input  rd_data, empty, full, count, overrun
  );

  modport slave (
    input  rx_data, rda, rd_en, clr_ovr,
    output rd_data, empty, full, count, overrun
  );

endinterface : rx_fifo_if

// File: rtl/spart_fifo_mem.sv
// DEPTH x byte register array: one synchronous write port, one asynchronous
// read port. Contents are deliberately not reset.
//   clk          : system clock
//   we, waddr,
//   wdata        : write port, written at the rising edge when we=1
//   raddr, rdata : combinational read port
module spart_fifo_mem
  import spart_pkg::*;
#(
  parameter int unsigned DEPTH = RX_FIFO_DEPTH,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  byte_t         wdata,
  input  logic [AW-1:0] raddr,
  output byte_t         rdata
);

  byte_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = mem_q[raddr];
  end

endmodule : spart_fifo_mem

// File: rtl/rx_fifo.sv
// Receive buffer between the UART receiver and the processor bus interface.
// Captures one byte per rising edge of rda into a circular FIFO; the bus side
// drains at its own pace. A push into a full FIFO (with no concurrent pop) is
// dropped and latches the sticky overrun flag.
//   clk : system clock
//   rst : synchronous, active-high reset
//   bus : rx_fifo_if slave modport (rx_data, rda, rd_en, clr_ovr in;
//         rd_data, empty, full, count, overrun out)
module rx_fifo
  import spart_pkg::*;
#(
  parameter int unsigned DEPTH = RX_FIFO_DEPTH,
  parameter int unsigned AW    = 4
) (
  input  logic      clk,
  input  logic      rst,
  rx_fifo_if.slave  bus
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic          rda_q,    rda_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          overrun_q, overrun_d;

  logic  push, pop, do_push, drop;
  byte_t mem_rdata;

  always_comb begin
    push = bus.rda & ~rda_q;
    pop  = bus.rd_en & (count_q != '0);
    // A pop frees the slot this same edge, so a push into a full FIFO with a
    // concurrent pop is accepted (wr_ptr == rd_ptr; the old head is read
    // combinationally before the edge overwrites it).
    do_push = push & ((count_q != FULL_CNT) | pop);
    drop    = push & ~do_push;

    rda_d    = bus.rda;
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(pop);

    overrun_d = overrun_q;
    if (bus.clr_ovr) overrun_d = 1'b0;
    if (drop)        overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rda_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      rda_q     <= rda_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  spart_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (do_push & ~rst),
    .waddr (wr_ptr_q),
    .wdata (bus.rx_data),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  always_comb begin
    bus.empty   = (count_q == '0);
    bus.full    = (count_q == FULL_CNT);
    bus.count   = count_q;
    bus.overrun = overrun_q;
    bus.rd_data = (count_q == '0) ? '0 : mem_rdata;
  end

endmodule : rx_fifo

// File: tb/tb_rx_fifo.sv
// Self-checking bench for rx_fifo: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_rx_fifo;
  import spart_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rx_fifo_if #(.AW(AW)) bus ();

  rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model
  byte_t m_q[$];
  bit    m_ovr;
  bit    m_rda_prev;

  function automatic byte_t m_head();
    return (m_q.size() > 0) ? m_q[0] : 8'h00;
  endfunction

  // Advance one clock: the model consumes the inputs present at the edge.
  task automatic tick();
    bit push, drop;
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      m_ovr      = 1'b0;
      m_rda_prev = 1'b0;
    end else begin
      push = bus.rda && !m_rda_prev;
      drop = push && (m_q.size() == DEPTH) && !bus.rd_en;
      if (bus.rd_en && m_q.size() > 0) void'(m_q.pop_front());
      if (push && !drop) m_q.push_back(bus.rx_data);
      if (bus.clr_ovr) m_ovr = 1'b0;
      if (drop) m_ovr = 1'b1;
      m_rda_prev = bus.rda;
    end
    #1;
  endtask

  task automatic push_byte(input byte_t b);
    bus.rx_data = b;
    bus.rda     = 1'b1;
    tick();
    bus.rda     = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", bus.full); end
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", bus.overrun); end
    checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got=%h exp=00", bus.rd_data); end
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    tick();
    checks++; if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.overrun !== 1'b0 || bus.rd_data !== 8'h00) begin
      errors++; $display("FAIL empty_pop got count=%0d empty=%b ovr=%b rd=%h exp 0/1/0/00",
                         bus.count, bus.empty, bus.overrun, bus.rd_data);
    end
  endtask

  task automatic test_level_rda();
    bus.rx_data = 8'h55;
    bus.rda     = 1'b1;
    tick();
    checks++; if (bus.count !== 5'd1 || bus.rd_data !== 8'h55) begin
      errors++; $display("FAIL level_first got count=%0d rd=%h exp 1/55", bus.count, bus.rd_data);
    end
    for (int i = 0; i < 40; i++) begin
      bus.rx_data = byte_t'($urandom);
      tick();
    end
    checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL level_hold got count=%0d exp=1", bus.count); end
    bus.rda   = 1'b0;
    bus.rd_en = 1'b1;
    checks++; if (bus.rd_data !== 8'h55) begin errors++; $display("FAIL level_pop_data got=%h exp=55", bus.rd_data); end
    tick();
    bus.rd_en = 1'b0;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL level_empty got=%b exp=1", bus.empty); end
  endtask

  task automatic test_order();
    push_byte(8'h55);
    push_byte(8'hAA);
    checks++; if (bus.count !== 5'd2 || bus.rd_data !== 8'h55) begin
      errors++; $display("FAIL order_0 got count=%0d rd=%h exp 2/55", bus.count, bus.rd_data);
    end
    bus.rd_en = 1'b1;
    tick();
    checks++; if (bus.count !== 5'd1 || bus.rd_data !== 8'hAA) begin
      errors++; $display("FAIL order_1 got count=%0d rd=%h exp 1/aa", bus.count, bus.rd_data);
    end
    tick();
    bus.rd_en = 1'b0;
    checks++; if (bus.count !== 5'd0 || bus.rd_data !== 8'h00) begin
      errors++; $display("FAIL order_2 got count=%0d rd=%h exp 0/00", bus.count, bus.rd_data);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 17; i++) begin
      push_byte(byte_t'(i));
      if (i == 15) begin
        checks++; if (bus.full !== 1'b1 || bus.overrun !== 1'b0) begin
          errors++; $display("FAIL ovf_full got full=%b ovr=%b exp 1/0", bus.full, bus.overrun);
        end
      end
    end
    checks++; if (bus.overrun !== 1'b1 || bus.count !== 5'd16) begin
      errors++; $display("FAIL ovf_drop got ovr=%b count=%0d exp 1/16", bus.overrun, bus.count);
    end
    bus.rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++; if (bus.rd_data !== byte_t'(i)) begin
        errors++; $display("FAIL ovf_pop%0d got=%h exp=%h", i, bus.rd_data, byte_t'(i));
      end
      tick();
    end
    bus.rd_en = 1'b0;
    checks++; if (bus.empty !== 1'b1 || bus.rd_data !== 8'h00) begin
      errors++; $display("FAIL ovf_drained got empty=%b rd=%h exp 1/00", bus.empty, bus.rd_data);
    end
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", bus.overrun); end
    bus.clr_ovr = 1'b1;
    tick();
    bus.clr_ovr = 1'b0;
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", bus.overrun); end
  endtask

  task automatic test_full_push_pop();
    byte_t last;
    for (int i = 0; i < 16; i++) push_byte(byte_t'(8'h80 + i));
    bus.rx_data = 8'hEE;
    bus.rda     = 1'b1;
    bus.rd_en   = 1'b1;
    tick();
    bus.rda   = 1'b0;
    bus.rd_en = 1'b0;
    checks++; if (bus.count !== 5'd16 || bus.overrun !== 1'b0 || bus.full !== 1'b1) begin
      errors++; $display("FAIL fpp_state got count=%0d ovr=%b full=%b exp 16/0/1",
                         bus.count, bus.overrun, bus.full);
    end
    last = 8'h00;
    bus.rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++; if (bus.rd_data !== m_head()) begin
        errors++; $display("FAIL fpp_pop%0d got=%h exp=%h", i, bus.rd_data, m_head());
      end
      last = bus.rd_data;
      tick();
    end
    bus.rd_en = 1'b0;
    checks++; if (last !== 8'hEE) begin errors++; $display("FAIL fpp_last got=%h exp=ee", last); end
  endtask

  task automatic test_reset_mid();
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.rd_data !== 8'h00) begin
      errors++; $display("FAIL rstmid got count=%0d empty=%b rd=%h exp 0/1/00",
                         bus.count, bus.empty, bus.rd_data);
    end
    push_byte(8'h3C);
    checks++; if (bus.rd_data !== 8'h3C || bus.count !== 5'd1) begin
      errors++; $display("FAIL rstmid_push got rd=%h count=%0d exp 3c/1", bus.rd_data, bus.count);
    end
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic test_random();
    int rd_pct;
    for (int c = 0; c < 3000; c++) begin
      // Alternate fill-heavy and drain-heavy phases to reach both boundaries.
      rd_pct = ((c / 200) % 2 == 0) ? 15 : 70;
      bus.rx_data = byte_t'($urandom);
      bus.rda     = ($urandom_range(99, 0) < 45);
      bus.rd_en   = ($urandom_range(99, 0) < rd_pct);
      bus.clr_ovr = ($urandom_range(99, 0) < 4);
      rst         = ($urandom_range(999, 0) < 3);
      tick();
      checks++;
      if (bus.count !== (AW+1)'(m_q.size()) || bus.empty !== (m_q.size() == 0) ||
          bus.full !== (m_q.size() == DEPTH) || bus.overrun !== m_ovr ||
          bus.rd_data !== m_head()) begin
        errors++;
        $display("FAIL rand_c%0d got count=%0d empty=%b full=%b ovr=%b rd=%h exp count=%0d ovr=%b rd=%h",
                 c, bus.count, bus.empty, bus.full, bus.overrun, bus.rd_data,
                 m_q.size(), m_ovr, m_head());
      end
    end
    bus.rda     = 1'b0;
    bus.rd_en   = 1'b0;
    bus.clr_ovr = 1'b0;
    rst         = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    bus.rx_data = '0;
    bus.rda     = 1'b0;
    bus.rd_en   = 1'b0;
    bus.clr_ovr = 1'b0;
    m_q.delete();
    m_ovr      = 1'b0;
    m_rda_prev = 1'b0;

    test_reset();
    test_level_rda();
    test_order();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_random();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_rx_fifo
